fib_hash_arbiter: RTL and testbench

FIB_HASH_ARBITER -- requirements
Module: fib_hash_arbiter

---
 rtl/fib_hash_arbiter.sv | 123 ++++++++++++
 tb/tb_fib_hash_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_hash_arbiter.sv
// Shares one external Fibonacci hash unit between the insert and lookup paths,
// one operation at a time. Define FIB_HASH_ARB_LKP_PRIO_EN for fixed lookup priority on ties.
module fib_hash_arbiter #(
    parameter int HASH_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ins_req,
    input  logic [63:0] ins_prefix,
    input  logic [5:0]  ins_len,
    output logic        ins_gnt,
    output logic        ins_hash_valid,
    output logic [9:0]  ins_hash,
    input  logic        lkp_req,
    input  logic [63:0] lkp_prefix,
    input  logic [5:0]  lkp_len,
    output logic        lkp_gnt,
    output logic        lkp_hash_valid,
    output logic [9:0]  lkp_hash,
    output logic [63:0] hash_prefix_in,
    output logic [5:0]  hash_len_in,
    input  logic [9:0]  hash_value,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [3:0] LAT_LOAD   = 4'(HASH_LAT);

    logic [1:0] state;
    logic [3:0] wait_cnt;
    logic       tag_lkp;
    logic       pick_lkp;
    logic       any_req;
`ifndef FIB_HASH_ARB_LKP_PRIO_EN
    logic       last_lkp;
`endif

    // Winner selection; on a tie the side that lost last time goes next.
    always_comb begin
        any_req  = ins_req | lkp_req;
        pick_lkp = lkp_req;
        if (ins_req && lkp_req) begin
`ifdef FIB_HASH_ARB_LKP_PRIO_EN
            pick_lkp = 1'b1;
`else
            pick_lkp = ~last_lkp;
`endif
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            wait_cnt       <= 4'd0;
            tag_lkp        <= 1'b0;
            ins_gnt        <= 1'b0;
            lkp_gnt        <= 1'b0;
            hash_prefix_in <= 64'd0;
            hash_len_in    <= 6'd0;
`ifndef FIB_HASH_ARB_LKP_PRIO_EN
            last_lkp       <= 1'b0;
`endif
        end else begin
            ins_gnt <= 1'b0;
            lkp_gnt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        hash_prefix_in <= pick_lkp ? lkp_prefix : ins_prefix;
                        hash_len_in    <= pick_lkp ? lkp_len : ins_len;
                        ins_gnt        <= ~pick_lkp;
                        lkp_gnt        <= pick_lkp;
                        wait_cnt       <= LAT_LOAD;
                        tag_lkp        <= pick_lkp;
`ifndef FIB_HASH_ARB_LKP_PRIO_EN
                        last_lkp       <= pick_lkp;
`endif
                        state          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Results stay put until the same requester captures again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ins_hash       <= 10'd0;
            lkp_hash       <= 10'd0;
            ins_hash_valid <= 1'b0;
            lkp_hash_valid <= 1'b0;
        end else begin
            ins_hash_valid <= 1'b0;
            lkp_hash_valid <= 1'b0;
            if (state == ST_CAPTURE) begin
                if (tag_lkp) begin
                    lkp_hash       <= hash_value;
                    lkp_hash_valid <= 1'b1;
                end else begin
                    ins_hash       <= hash_value;
                    ins_hash_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fib_hash_arbiter.sv
// Directed bench for fib_hash_arbiter: three instances (HASH_LAT 1, 2, 15) share
// the request inputs, each with its own behavioural hash unit.
module tb_fib_hash_arbiter;

    logic        clk;
    logic        rst;
    logic        ins_req;
    logic [63:0] ins_prefix;
    logic [5:0]  ins_len;
    logic        lkp_req;
    logic [63:0] lkp_prefix;
    logic [5:0]  lkp_len;

    logic        ins_gnt        [3];
    logic        ins_hash_valid [3];
    logic [9:0]  ins_hash       [3];
    logic        lkp_gnt        [3];
    logic        lkp_hash_valid [3];
    logic [9:0]  lkp_hash       [3];
    logic [63:0] hash_prefix_in [3];
    logic [5:0]  hash_len_in    [3];
    logic [9:0]  hash_value     [3];
    logic        busy           [3];

    int errors = 0;
    int checks = 0;

    function automatic logic [9:0] fib_hash(input logic [63:0] p, input logic [5:0] l);
        logic [63:0] m;
        logic [63:0] prod;
        m    = p & ((64'd1 << l) - 64'd1);
        prod = (m ^ {58'd0, l}) * 64'h9E37_79B9_7F4A_7C15;
        return prod[63:54];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fib_hash_arbiter #(
            .HASH_LAT((g == 0) ? 1 : (g == 1) ? 2 : 15)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .ins_req       (ins_req),
            .ins_prefix    (ins_prefix),
            .ins_len       (ins_len),
            .ins_gnt       (ins_gnt[g]),
            .ins_hash_valid(ins_hash_valid[g]),
            .ins_hash      (ins_hash[g]),
            .lkp_req       (lkp_req),
            .lkp_prefix    (lkp_prefix),
            .lkp_len       (lkp_len),
            .lkp_gnt       (lkp_gnt[g]),
            .lkp_hash_valid(lkp_hash_valid[g]),
            .lkp_hash      (lkp_hash[g]),
            .hash_prefix_in(hash_prefix_in[g]),
            .hash_len_in   (hash_len_in[g]),
            .hash_value    (hash_value[g]),
            .busy          (busy[g])
        );
        assign hash_value[g] = fib_hash(hash_prefix_in[g], hash_len_in[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ins_r, input logic lkp_r);
        ins_req = ins_r;
        lkp_req = lkp_r;
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    initial begin
        int ngr;
        int since;
        int gnt_cyc[$];
        logic exp_lkp;
        logic [9:0] pulses;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        ins_prefix = 64'd0; ins_len = 6'd0;
        lkp_prefix = 64'd0; lkp_len = 6'd0;
        #3 rst = 1'b0;
        repeat (2) tick();

        $display("[TB] reset state");
        for (int g = 0; g < 3; g++) begin
            checkOutput("rst_busy", busy[g], 0);
            checkOutput("rst_ins_gnt", ins_gnt[g], 0);
            checkOutput("rst_lkp_gnt", lkp_gnt[g], 0);
            checkOutput("rst_ins_hv", ins_hash_valid[g], 0);
            checkOutput("rst_lkp_hv", lkp_hash_valid[g], 0);
            checkOutput("rst_ins_hash", ins_hash[g], 0);
            checkOutput("rst_lkp_hash", lkp_hash[g], 0);
            checkOutput("rst_prefix", hash_prefix_in[g], 0);
            checkOutput("rst_len", hash_len_in[g], 0);
        end
        rst = 1'b1;

        $display("[TB] single insert, HASH_LAT=1");
        ins_prefix = 64'h0000_0000_0000_00AB; ins_len = 6'd8;
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("t1_ins_gnt", ins_gnt[0], 1);
        checkOutput("t1_prefix", hash_prefix_in[0], 64'hAB);
        checkOutput("t1_len", hash_len_in[0], 8);
        checkOutput("t1_busy", busy[0], 1);
        applyStimulus(1'b0, 1'b0);
        tick();
        checkOutput("t1_gnt_drop", ins_gnt[0], 0);
        checkOutput("t1_hv_early", ins_hash_valid[0], 0);
        tick();
        checkOutput("t1_hv", ins_hash_valid[0], 1);
        checkOutput("t1_hash", ins_hash[0], fib_hash(64'hAB, 6'd8));
        checkOutput("t1_lkp_gnt", lkp_gnt[0], 0);
        checkOutput("t1_lkp_hv", lkp_hash_valid[0], 0);
        checkOutput("t1_lkp_hash", lkp_hash[0], 0);
        tick();
        checkOutput("t1_hv_once", ins_hash_valid[0], 0);
        checkOutput("t1_hold", ins_hash[0], fib_hash(64'hAB, 6'd8));
        checkOutput("t1_prefix_hold", hash_prefix_in[0], 64'hAB);
        checkOutput("t1_idle", busy[0], 0);

        $display("[TB] both requesting, HASH_LAT=2");
        applyReset();
        ins_prefix = 64'h1234; ins_len = 6'd16;
        lkp_prefix = 64'hFFFF_0000_0000_0001; lkp_len = 6'd63;
        applyStimulus(1'b1, 1'b1);
        ngr = 0;
        for (int c = 0; c < 40 && ngr < 4; c++) begin
            tick();
            checkOutput("t2_gnt_excl", {63'd0, ins_gnt[1] & lkp_gnt[1]}, 0);
            checkOutput("t2_hv_excl", {63'd0, ins_hash_valid[1] & lkp_hash_valid[1]}, 0);
            if (ins_gnt[1] || lkp_gnt[1]) begin
`ifdef FIB_HASH_ARB_LKP_PRIO_EN
                exp_lkp = 1'b1;
`else
                exp_lkp = (ngr % 2 == 0);
`endif
                checkOutput("t2_order", lkp_gnt[1], exp_lkp);
                checkOutput("t2_prefix", hash_prefix_in[1], exp_lkp ? lkp_prefix : ins_prefix);
                ngr++;
            end
            if (lkp_hash_valid[1])
                checkOutput("t2_lkp_hash", lkp_hash[1], fib_hash(lkp_prefix, lkp_len));
            if (ins_hash_valid[1])
                checkOutput("t2_ins_hash", ins_hash[1], fib_hash(ins_prefix, ins_len));
        end
        checkOutput("t2_grants", ngr, 4);

        $display("[TB] lookup arrives while insert busy, HASH_LAT=2");
        applyReset();
        ins_prefix = 64'h5555; ins_len = 6'd20;
        lkp_prefix = 64'h0F0F_0F0F; lkp_len = 6'd32;
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("t3_ins_gnt", ins_gnt[1], 1);
        applyStimulus(1'b0, 1'b1);
        tick();
        checkOutput("t3_no_gnt_w1", lkp_gnt[1], 0);
        tick();
        checkOutput("t3_no_gnt_w2", lkp_gnt[1], 0);
        tick();
        checkOutput("t3_ins_hv", ins_hash_valid[1], 1);
        checkOutput("t3_no_gnt_cap", lkp_gnt[1], 0);
        tick();
        checkOutput("t3_lkp_gnt", lkp_gnt[1], 1);
        checkOutput("t3_prefix", hash_prefix_in[1], 64'h0F0F_0F0F);
        applyStimulus(1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("t3_lkp_hv", lkp_hash_valid[1], 1);
        checkOutput("t3_lkp_hash", lkp_hash[1], fib_hash(64'h0F0F_0F0F, 6'd32));

        $display("[TB] reset during lookup wait, HASH_LAT=2");
        applyReset();
        lkp_prefix = 64'h00AA_BBCC; lkp_len = 6'd24;
        applyStimulus(1'b0, 1'b1);
        tick();
        checkOutput("t4_lkp_gnt", lkp_gnt[1], 1);
        applyStimulus(1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("t4_busy", busy[1], 0);
        checkOutput("t4_prefix", hash_prefix_in[1], 0);
        checkOutput("t4_len", hash_len_in[1], 0);
        checkOutput("t4_lkp_hash", lkp_hash[1], 0);
        repeat (2) tick();
        rst = 1'b1;
        pulses = 10'd0;
        for (int c = 0; c < 6; c++) begin
            tick();
            pulses = pulses + {9'd0, lkp_hash_valid[1]};
        end
        checkOutput("t4_no_hv", pulses, 0);
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("t4_tie_lkp", lkp_gnt[1], 1);
        checkOutput("t4_tie_ins", ins_gnt[1], 0);
        applyStimulus(1'b0, 1'b0);

        $display("[TB] back-to-back inserts, HASH_LAT=15");
        applyReset();
        ins_prefix = 64'hDEAD_BEEF; ins_len = 6'd40;
        applyStimulus(1'b1, 1'b0);
        since = -1;
        for (int c = 0; c < 80 && gnt_cyc.size() < 3; c++) begin
            tick();
            if (ins_gnt[2]) begin
                gnt_cyc.push_back(c);
                since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if (since >= 0)
                checkOutput("t5_busy", busy[2], (since == 16) ? 0 : 1);
        end
        checkOutput("t5_grants", gnt_cyc.size(), 3);
        if (gnt_cyc.size() == 3) begin
            checkOutput("t5_gap1", gnt_cyc[1] - gnt_cyc[0], 17);
            checkOutput("t5_gap2", gnt_cyc[2] - gnt_cyc[1], 17);
        end
        checkOutput("t5_hash", ins_hash[2], fib_hash(64'hDEAD_BEEF, 6'd40));
        applyStimulus(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
